// File: rtl/uart16550_axil_tx.sv
// UART16550 transmit serializer: pops bytes from the TX FIFO and shifts them out
// as start / 5-8 data / optional parity / 1, 1.5 or 2 stop bits, timed by a 16x baud enable.
module uart16550_axil_tx #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baudce,
  input  logic [7:0] fifo_odata,
  input  logic       fifo_empty,
  output logic       fifo_read,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       bc,
  output logic       txd,
  output logic       thre,
  output logic       temt,
  output logic       busy
);

  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [2:0]    bcnt, bcnt_n;
  logic [7:0]    shift, shift_n;
  logic [1:0]    l_wls, l_wls_n;
  logic          l_stb, l_stb_n;
  logic          l_pen, l_pen_n;
  logic          par, par_n;
  logic          bit_end;
  logic          line_n;
  logic [7:0]    dmask;
  logic          par_calc;

  // Parity is resolved once, when the byte is popped, over the active bits only.
  always_comb begin
    dmask    = 8'hFF >> (2'd3 - wls);
    par_calc = sp ? ~eps : (eps ? ^(fifo_odata & dmask) : ~^(fifo_odata & dmask));
  end

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    bcnt_n  = bcnt;
    shift_n = shift;
    l_wls_n = l_wls;
    l_stb_n = l_stb;
    l_pen_n = l_pen;
    par_n   = par;
    bit_end = baudce && (tcnt == T_LAST);
    if (state != IDLE && baudce) tcnt_n = tcnt + T_ONE;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_n = START;
          tcnt_n  = '0;
          bcnt_n  = '0;
          shift_n = fifo_odata;
          l_wls_n = wls;
          l_stb_n = stb;
          l_pen_n = pen;
          par_n   = par_calc;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bcnt_n  = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = {1'b0, shift[7:1]};
          bcnt_n  = bcnt + 3'd1;
          if (bcnt == {1'b0, l_wls} + 3'd4) begin
            state_n = l_pen ? PARITY : STOP;
            bcnt_n  = '0;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          bcnt_n  = '0;
        end
      end
      STOP: begin
        // bcnt counts completed stop periods; the 1.5-bit case ends halfway through the second.
        if (baudce) begin
          if (l_stb && l_wls == 2'd0 && bcnt == 3'd1 && tcnt == T_HALF) begin
            state_n = IDLE;
            tcnt_n  = '0;
            bcnt_n  = '0;
          end else if (bit_end) begin
            if (!l_stb || bcnt == 3'd1) begin
              state_n = IDLE;
              bcnt_n  = '0;
            end else begin
              bcnt_n = 3'd1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shift_n[0];
      PARITY:  line_n = par_n;
      default: line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      shift <= '0;
      l_wls <= '0;
      l_stb <= 1'b0;
      l_pen <= 1'b0;
      par   <= 1'b0;
      txd   <= 1'b1;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
      bcnt  <= bcnt_n;
      shift <= shift_n;
      l_wls <= l_wls_n;
      l_stb <= l_stb_n;
      l_pen <= l_pen_n;
      par   <= par_n;
      txd   <= ~bc & line_n;
    end
  end

  // Handshake: fifo_read pops the head in any cycle it is high, and it is only raised while
  // fifo_empty is low; fifo_odata is taken in that same cycle and the FIFO advances afterwards.
  assign fifo_read = !reset && (state == IDLE) && !fifo_empty;
  assign thre      = fifo_empty;
  assign temt      = fifo_empty && (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_uart16550_axil_tx.sv
// Randomized bench for uart16550_axil_tx: a FIFO model feeds the DUT and a per-tick line
// model built from the frame rules predicts txd/busy/fifo_read/temt every cycle.
module tb_uart16550_axil_tx;
  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baudce = 1'b0;
  logic [7:0] fifo_odata = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_read;
  logic [1:0] wls = 2'd3;
  logic       stb = 1'b0, pen = 1'b0, eps = 1'b0, sp = 1'b0, bc = 1'b0;
  logic       txd, thre, temt, busy;

  int n_checks = 0;
  int n_errors = 0;
  int pops = 0;
  int n_sent = 0;
  int baud_div = 1;
  bit baud_rand = 1'b0;
  int div_cnt = 0;
  bit mon_en = 1'b0;
  logic bc_q = 1'b0;
  logic rst_q = 1'b1;

  logic [7:0] fifo_q[$];
  logic [7:0] push_q[$];
  logic [0:0] exp_q[$];

  uart16550_axil_tx #(.OVS(OVS)) dut (
    .clk(clk), .reset(reset), .baudce(baudce),
    .fifo_odata(fifo_odata), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
    .wls(wls), .stb(stb), .pen(pen), .eps(eps), .sp(sp), .bc(bc),
    .txd(txd), .thre(thre), .temt(temt), .busy(busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level for every baud tick of one frame.
  function automatic void add_frame(input logic [7:0] d, input logic [1:0] w,
                                    input logic s, input logic p, input logic e, input logic k);
    int   nb, ones, stop_ticks;
    logic pbit;
    nb   = int'(w) + 5;
    ones = 0;
    repeat (OVS) exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      ones += int'(d[i]);
      repeat (OVS) exp_q.push_back(d[i]);
    end
    if (p) begin
      pbit = k ? !e : (e ? ones[0] : !ones[0]);
      repeat (OVS) exp_q.push_back(pbit);
    end
    stop_ticks = !s ? OVS : ((w == 2'd0) ? OVS + OVS / 2 : 2 * OVS);
    repeat (stop_ticks) exp_q.push_back(1'b1);
  endfunction

  // FIFO model and line reference model, both advanced on the clock edge.
  always @(posedge clk) begin : fifo_and_model
    bit         model_pop;
    logic [7:0] head;
    head      = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    model_pop = !reset && (exp_q.size() == 0) && (fifo_q.size() != 0);
    if (fifo_read && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    if (reset) exp_q.delete();
    else if (exp_q.size() != 0 && baudce) void'(exp_q.pop_front());
    if (model_pop) add_frame(head, wls, stb, pen, eps, sp);
    while (push_q.size() != 0) fifo_q.push_back(push_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
    fifo_odata <= (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    bc_q  = bc;
    rst_q = reset;
  end

  always @(posedge clk) begin : baud_gen
    #1;
    if (baud_rand) baudce = ($urandom_range(0, 2) == 0);
    else begin
      div_cnt = (div_cnt + 1 >= baud_div) ? 0 : div_cnt + 1;
      baudce  = (div_cnt == 0);
    end
  end

  // scoreboard: compare every cycle away from the active edge
  always @(negedge clk) begin : monitor
    logic exp_txd;
    if (mon_en) begin
      exp_txd = rst_q ? 1'b1 : (bc_q ? 1'b0 : ((exp_q.size() != 0) ? exp_q[0][0] : 1'b1));
      check("txd", txd, exp_txd);
      check("busy", busy, exp_q.size() != 0);
      check("fifo_read", fifo_read, !reset && (exp_q.size() == 0) && !fifo_empty);
      check("thre", thre, fifo_empty);
      check("temt", temt, fifo_empty && (exp_q.size() == 0));
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] w,
                      input logic s, input logic p, input logic e, input logic k);
    wls = w; stb = s; pen = p; eps = e; sp = k;
    push_q.push_back(d);
    n_sent++;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && push_q.size() == 0 && !busy) && n < limit) begin
      tick(1);
      n++;
    end
    check("idle_timeout", n < limit, 1'b1);
    tick(2);
  endtask

  initial begin
    int p0;
    reset = 1'b1;
    tick(3);
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_fifo_read", fifo_read, 1'b0);
    check("rst_thre", thre, 1'b1);
    check("rst_temt", temt, 1'b1);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // 8N1 0x55 with baudce every cycle: idle again after exactly 160 ticks
    baud_div = 1;
    p0 = pops;
    send(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(161);
    check("8n1_temt_early", temt, 1'b0);
    tick(1);
    check("8n1_temt", temt, 1'b1);
    check("8n1_pops", pops - p0, 1);
    wait_idle(2000);

    // parity, stop length and stick parity cases
    send(8'h07, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0); wait_idle(2000);
    send(8'h07, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0); wait_idle(2000);
    send(8'h00, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0); wait_idle(2000);
    send(8'hFF, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0); wait_idle(2000);
    send(8'hFF, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0); wait_idle(2000);
    send(8'h01, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1); wait_idle(2000);
    send(8'h03, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1); wait_idle(2000);
    send(8'h01, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1); wait_idle(2000);
    send(8'h03, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1); wait_idle(2000);

    // three queued bytes, baudce every 4 cycles, back-to-back frames
    baud_div = 4;
    p0 = pops;
    send(8'hA1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'hB2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle(8000);
    check("burst_pops", pops - p0, 3);

    // break mid-frame while the FIFO keeps draining
    baud_div = 2;
    p0 = pops;
    send(8'h3C, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    send(8'hC5, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(40);
    bc = 1'b1;
    tick(1);
    check("break_txd", txd, 1'b0);
    tick(300);
    bc = 1'b0;
    wait_idle(4000);
    check("break_pops", pops - p0, 2);

    // reset in the middle of the data bits aborts the frame
    baud_div = 1;
    send(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2 + OVS + 3 * OVS + 5);
    check("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    tick(1);
    check("mid_reset_txd", txd, 1'b1);
    check("mid_reset_busy", busy, 1'b0);
    check("mid_reset_fifo_read", fifo_read, 1'b0);
    reset = 1'b0;
    tick(2);
    send(8'h96, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle(2000);

    // randomized frames, baud spacing, mid-frame config changes and break pulses
    for (int it = 0; it < 40; it++) begin
      int nb;
      baud_rand = ($urandom_range(0, 3) == 0);
      baud_div  = $urandom_range(1, 3);
      nb        = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++)
        send(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick($urandom_range(1, 120));
      wls = 2'($urandom_range(0, 3));
      pen = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin
        bc = 1'b1;
        tick($urandom_range(1, 40));
        bc = 1'b0;
      end
      wait_idle(6000);
    end
    baud_rand = 1'b0;

    check("total_pops", pops, n_sent);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
